// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, error codes, default timing, odd parity.
// Used by the host transmitter and the keyboard receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_SHIFT,
    ST_WAIT_IDLE,
    ST_DONE,
    ST_ERR
  } ps2_tx_state_t;

  localparam logic [1:0] PS2_ERR_NONE    = 2'b00;
  localparam logic [1:0] PS2_ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] PS2_ERR_NOACK   = 2'b10;

  // 100 us inhibit and 15 ms watchdog at a 50 MHz system clock
  localparam int PS2_INHIBIT_CYCLES = 5000;
  localparam int PS2_TIMEOUT_CYCLES = 750000;

  function automatic logic ps2_odd_par(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between the host logic (master) and the PS/2 transmitter (slave).
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_err;
  logic [1:0] tx_err_code;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, tx_done, tx_err, tx_err_code
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, tx_done, tx_err, tx_err_code
  );
endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the PS/2 clock and data pads plus a one-cycle clock falling-edge pulse.
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_clk_pad,
  input  logic i_dat_pad,
  output logic o_clk_s,
  output logic o_dat_s,
  output logic o_clk_fe
);
  logic [1:0] r_clk_sync;
  logic [1:0] r_dat_sync;
  logic       r_clk_prev;

  // Idle PS/2 lines are pulled high, so reset to 1 to avoid a false edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[0], i_clk_pad};
      r_dat_sync <= {r_dat_sync[0], i_dat_pad};
      r_clk_prev <= r_clk_sync[1];
    end
  end

  assign o_clk_s  = r_clk_sync[1];
  assign o_dat_s  = r_dat_sync[1];
  assign o_clk_fe = r_clk_prev & ~r_clk_sync[1];
endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, device-clocked shift, ack check.
// Optional macro PS2_TX_RETRY_EN: a failed byte is retried once before tx_err is reported.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
  input  logic          clk,
  input  logic          reset,
  ps2_host_tx_if.slave  bus,
  input  logic          ps2_clk_i,
  input  logic          ps2_dat_i,
  output logic          ps2_clk_oe,
  output logic          ps2_dat_oe
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  ps2_tx_state_t    r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]       r_bit, w_bit_nxt;
  logic [7:0]       r_byte, w_byte_nxt;
  logic [1:0]       r_code, w_code_nxt;
  logic             r_clk_oe, w_clk_oe_nxt;
  logic             r_dat_oe, w_dat_oe_nxt;
  logic             w_fail;
  logic [1:0]       w_fail_code;
  logic             w_clk_s, w_dat_s, w_fe;
`ifdef PS2_TX_RETRY_EN
  logic             r_retried, w_retried_nxt;
`endif

  ps2_line_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .i_clk_pad (ps2_clk_i),
    .i_dat_pad (ps2_dat_i),
    .o_clk_s   (w_clk_s),
    .o_dat_s   (w_dat_s),
    .o_clk_fe  (w_fe)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt + 1'b1;
    w_bit_nxt    = r_bit;
    w_byte_nxt   = r_byte;
    w_code_nxt   = r_code;
    w_clk_oe_nxt = r_clk_oe;
    w_dat_oe_nxt = r_dat_oe;
    w_fail       = 1'b0;
    w_fail_code  = PS2_ERR_NONE;
`ifdef PS2_TX_RETRY_EN
    w_retried_nxt = r_retried;
`endif
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (bus.tx_valid) begin
          w_state_nxt  = ST_INHIBIT;
          w_byte_nxt   = bus.tx_data;
          w_clk_oe_nxt = 1'b1;
`ifdef PS2_TX_RETRY_EN
          w_retried_nxt = 1'b0;
`endif
        end
      end
      ST_INHIBIT: begin
        if (r_cnt == INH_LAST) begin
          w_state_nxt  = ST_RTS;
          w_dat_oe_nxt = 1'b1;
        end
      end
      ST_RTS: begin
        w_state_nxt  = ST_SHIFT;
        w_clk_oe_nxt = 1'b0;
        w_cnt_nxt    = '0;
        w_bit_nxt    = '0;
      end
      // r_bit counts falling edges already seen; the watchdog restarts on each one
      ST_SHIFT: begin
        if (w_fe) begin
          w_cnt_nxt = '0;
          w_bit_nxt = r_bit + 4'd1;
          if (r_bit < 4'd8)       w_dat_oe_nxt = ~r_byte[r_bit[2:0]];
          else if (r_bit == 4'd8) w_dat_oe_nxt = ~ps2_odd_par(r_byte);
          else if (r_bit == 4'd9) w_dat_oe_nxt = 1'b0;
          else if (w_dat_s) begin
            w_fail      = 1'b1;
            w_fail_code = PS2_ERR_NOACK;
          end else begin
            w_state_nxt = ST_WAIT_IDLE;
          end
        end else if (r_cnt == TO_LAST) begin
          w_fail      = 1'b1;
          w_fail_code = PS2_ERR_TIMEOUT;
        end
      end
      ST_WAIT_IDLE: begin
        if (w_clk_s && w_dat_s) begin
          w_state_nxt = ST_DONE;
        end else if (w_fe) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == TO_LAST) begin
          w_fail      = 1'b1;
          w_fail_code = PS2_ERR_TIMEOUT;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_fail) begin
      w_state_nxt  = ST_ERR;
      w_code_nxt   = w_fail_code;
      w_clk_oe_nxt = 1'b0;
      w_dat_oe_nxt = 1'b0;
`ifdef PS2_TX_RETRY_EN
      if (!r_retried) begin
        w_state_nxt   = ST_INHIBIT;
        w_clk_oe_nxt  = 1'b1;
        w_cnt_nxt     = '0;
        w_retried_nxt = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_code   <= PS2_ERR_NONE;
      r_clk_oe <= 1'b0;
      r_dat_oe <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_bit    <= w_bit_nxt;
      r_code   <= w_code_nxt;
      r_clk_oe <= w_clk_oe_nxt;
      r_dat_oe <= w_dat_oe_nxt;
    end
  end

  always_ff @(posedge clk) begin
    r_byte <= w_byte_nxt;
  end

`ifdef PS2_TX_RETRY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_retried <= 1'b0;
    else       r_retried <= w_retried_nxt;
  end
`endif

  assign bus.tx_ready    = (r_state == ST_IDLE);
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.tx_done     = (r_state == ST_DONE);
  assign bus.tx_err      = (r_state == ST_ERR);
  assign bus.tx_err_code = r_code;
  assign ps2_clk_oe      = r_clk_oe;
  assign ps2_dat_oe      = r_dat_oe;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a PS/2 device model on open-drain lines (timing scaled down).
module tb_ps2_host_tx;
  localparam int INH  = 50;
  localparam int TO   = 600;
  localparam int HALF = 20;
`ifdef PS2_TX_RETRY_EN
  localparam int NTRY = 2;
`else
  localparam int NTRY = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ps2_clk_oe, ps2_dat_oe;
  logic dev_clk_low = 1'b0, dev_dat_low = 1'b0;
  logic clk_line, dat_line;
  int   n_chk = 0, n_fail = 0;
  int   n_done = 0, n_err = 0;

  ps2_host_tx_if bus ();

  assign clk_line = !(ps2_clk_oe || dev_clk_low);
  assign dat_line = !(ps2_dat_oe || dev_dat_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .ps2_clk_i  (clk_line),
    .ps2_dat_i  (dat_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (bus.tx_done) n_done <= n_done + 1;
    if (bus.tx_err)  n_err  <= n_err + 1;
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL global_timeout checks=%0d", n_chk);
    $fatal(1, "simulation did not finish");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    while (!bus.tx_ready && n < 2000) begin @(negedge clk); n++; end
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    check("accept_busy_ready", {30'd0, bus.busy, bus.tx_ready}, 32'd2);
  endtask

  // Device side: waits for request-to-send, generates nclk clocks, samples data after each rising edge
  task automatic device(input bit ack, input int nclk, output logic [7:0] rb,
                        output logic rp, output logic rs, output bit ok);
    int n = 0;
    rb = '0; rp = 1'b0; rs = 1'b0; ok = 1'b0;
    while (!(clk_line && !dat_line) && n < INH * 4) begin @(negedge clk); n++; end
    if (n >= INH * 4) return;
    repeat (5) @(negedge clk);
    for (int k = 1; k <= nclk; k++) begin
      if (k == 11 && ack) begin
        dev_dat_low = 1'b1;
        repeat (2) @(negedge clk);
      end
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      if (k <= 8)       rb[k-1] = dat_line;
      else if (k == 9)  rp = dat_line;
      else if (k == 10) rs = dat_line;
      repeat (HALF) @(negedge clk);
    end
    dev_dat_low = 1'b0;
    ok = 1'b1;
  endtask

  task automatic wait_result(input int budget, output bit d, output bit e, output logic [1:0] code,
                             output logic oc, output logic od, output bit to);
    int n = 0;
    while (!(bus.tx_done || bus.tx_err) && n < budget) begin @(negedge clk); n++; end
    d = bus.tx_done; e = bus.tx_err; code = bus.tx_err_code;
    oc = ps2_clk_oe; od = ps2_dat_oe; to = (n >= budget);
  endtask

  logic [7:0] cap;
  logic       cpar, cstop, goc, god;
  logic [1:0] gcode;
  bit         dok, gd, ge, gto;
  int         nd0, ne0, n_inh;

  initial begin
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", bus.tx_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_done_err", {bus.tx_done, bus.tx_err}, 0);
    check("rst_code", bus.tx_err_code, 0);
    check("rst_oe", {ps2_clk_oe, ps2_dat_oe}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 1: 0xED with ack
    nd0 = n_done; ne0 = n_err; n_inh = 0;
    fork
      send(8'hED);
      device(1'b1, 11, cap, cpar, cstop, dok);
      wait_result(4000, gd, ge, gcode, goc, god, gto);
      begin : t1_inh
        int n;
        n = 0;
        while (!ps2_clk_oe && n < 100) begin @(negedge clk); n++; end
        while (ps2_clk_oe && n_inh < 1000) begin @(negedge clk); n_inh++; end
      end
    join
    check("t1_inhibit_len_ok", n_inh >= INH, 1);
    check("t1_dev_ok", dok, 1);
    check("t1_byte", cap, 8'hED);
    check("t1_parity", cpar, 1);
    check("t1_stop", cstop, 1);
    check("t1_done", {gd, ge, gto}, 3'b100);
    repeat (3) @(negedge clk);
    check("t1_done_cnt", n_done - nd0, 1);
    check("t1_err_cnt", n_err - ne0, 0);
    check("t1_ready_after", bus.tx_ready, 1);

    // 2: 0x00
    nd0 = n_done;
    fork
      send(8'h00);
      device(1'b1, 11, cap, cpar, cstop, dok);
      wait_result(4000, gd, ge, gcode, goc, god, gto);
    join
    check("t2_byte", cap, 8'h00);
    check("t2_parity", cpar, 1);
    check("t2_done", {gd, ge, gto}, 3'b100);
    repeat (3) @(negedge clk);
    check("t2_done_cnt", n_done - nd0, 1);

    // 3: 0xFF, no ack
    ne0 = n_err; nd0 = n_done;
    fork
      send(8'hFF);
      for (int a = 0; a < NTRY; a++) device(1'b0, 11, cap, cpar, cstop, dok);
      wait_result(8000, gd, ge, gcode, goc, god, gto);
    join
    check("t3_byte", cap, 8'hFF);
    check("t3_parity", cpar, 1);
    check("t3_err", {gd, ge, gto}, 3'b010);
    check("t3_code", gcode, 2'b10);
    check("t3_oe_released", {goc, god}, 0);
    repeat (3) @(negedge clk);
    check("t3_err_cnt", n_err - ne0, 1);
    check("t3_done_cnt", n_done - nd0, 0);

    // 4: device never clocks
    fork
      send(8'h55);
      wait_result(TO * NTRY + 2000, gd, ge, gcode, goc, god, gto);
      begin : t4_meas
        int n;
        for (int a = 0; a < NTRY; a++) begin
          n = 0;
          while (!ps2_clk_oe && n < 200) begin @(negedge clk); n++; end
          n = 0;
          while (ps2_clk_oe && n < 200) begin @(negedge clk); n++; end
          n = 0;
          do begin @(negedge clk); n++; end while (!(bus.tx_err || ps2_clk_oe) && n < TO + 100);
          check("t4_timeout_len", n, TO);
        end
      end
    join
    check("t4_err", {gd, ge, gto}, 3'b010);
    check("t4_code", gcode, 2'b01);
    check("t4_oe_released", {goc, god}, 0);
    repeat (3) @(negedge clk);

    // 5: reset after fe 4 of 0xA5, then a clean resend
    nd0 = n_done; ne0 = n_err;
    fork
      send(8'hA5);
      device(1'b1, 4, cap, cpar, cstop, dok);
    join
    check("t5_pre_dat_oe", ps2_dat_oe, 1);
    check("t5_pre_busy", bus.busy, 1);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("t5_oe_async", {ps2_clk_oe, ps2_dat_oe}, 0);
    check("t5_ready_async", bus.tx_ready, 1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    check("t5_no_pulse", {n_done - nd0, n_err - ne0}, 0);
    fork
      send(8'hA5);
      device(1'b1, 11, cap, cpar, cstop, dok);
      wait_result(4000, gd, ge, gcode, goc, god, gto);
    join
    check("t5_byte", cap, 8'hA5);
    check("t5_parity", cpar, 1);
    check("t5_done", {gd, ge, gto}, 3'b100);

    // 6: tx_valid during an active transfer is ignored
    repeat (3) @(negedge clk);
    nd0 = n_done;
    fork
      send(8'hF4);
      device(1'b1, 11, cap, cpar, cstop, dok);
      wait_result(4000, gd, ge, gcode, goc, god, gto);
      begin : t6_poke
        repeat (200) @(negedge clk);
        bus.tx_data  = 8'h12;
        bus.tx_valid = 1'b1;
        check("t6_ready_while_busy", bus.tx_ready, 0);
        @(negedge clk);
        bus.tx_valid = 1'b0;
      end
    join
    check("t6_byte", cap, 8'hF4);
    check("t6_parity", cpar, 0);
    check("t6_done", {gd, ge, gto}, 3'b100);
    repeat (200) @(negedge clk);
    check("t6_done_cnt", n_done - nd0, 1);
    check("t6_idle_after", {bus.tx_ready, ps2_clk_oe}, 2'b10);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
